spi_receiver: RTL and testbench
===============================

# spi_receiver

Serial-to-parallel receive path of the SPI-lite core; the receive-direction counterpart of the transmit shifter. It samples `sdi` on single-cycle `sample` strobes from the SCK generator while `en` (frame active) is high, and assembles `DATA_W` bits MSB-first or LSB-first. Each completed word goes into a one-entry holding register, which is drained by a valid/ready handshake toward the APB register file.

## Interface
- `DATA_W`, default 8: word width in bits, at least 2.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `en`  in  1  frame active (chip-select asserted); a low level aborts any partial word.
- `sample`  in  1  one-cycle strobe at the SCK sampling edge.
- `sdi`  in  1  serial data in, sampled when `sample` is high.
- `lsbf`  in  1  1 selects LSB-first, 0 selects MSB-first; latched at frame start.
- `data_o`  out  `DATA_W`  received word from the holding register.
- `valid_o`  out  1  holding register is full.
- `ready_i`  in  1  consumer accepts `data_o` when `valid_o & ready_i`.
- `busy_o`  out  1  a partial word is in progress (bit count is nonzero).
- `ovr_o`  out  1  sticky overrun flag; exists only with `SPI_RX_OVR_EN`.
- `ovr_clr_i`  in  1  clears `ovr_o`; exists only with `SPI_RX_OVR_EN`.

## Operation
- The FSM has two states, IDLE and RECEIVE.
- **IDLE**
  - `sample` is ignored.
  - If `en`=1: go to RECEIVE, clear the bit counter, latch `lsbf`.
- **RECEIVE**, on each `sample`:
  - MSB-first: `shreg <= {shreg[DATA_W-2:0], sdi}`.
  - LSB-first: `shreg <= {sdi, shreg[DATA_W-1:1]}`.
  - The bit counter increments.
- **Word complete** (the `sample` that carries bit count `DATA_W-1`):
  - The holding register loads the fully shifted value on the same edge.
  - The counter wraps to 0 and the FSM stays in RECEIVE.
  - Back-to-back words need no gap.
- **`en` falls in RECEIVE:**
  - The FSM goes to IDLE next cycle and the partial word is discarded.
  - The holding register is unaffected.
  - A `sample` in a cycle with `en`=0 is ignored.
- **Handshake:**
  - `valid_o` sets on word completion.
  - `valid_o` clears on `valid_o & ready_i`.
  - `data_o` is stable while `valid_o`=1 and no transfer occurs.
- **Simultaneous completion and accept:** the new word loads, `valid_o` stays 1, no overrun.
- **Overrun:** completion while `valid_o`=1 and `ready_i`=0; handling is set by `SPI_RX_OVR_EN` (see Configuration).
- **`busy_o`** = (state == RECEIVE) & (counter != 0).
- **Reset:** state IDLE, counter 0, `shreg` 0, `data_o` 0, `valid_o` 0, `busy_o` 0, `ovr_o` 0.
  - Reset applies mid-word and discards all data.

## Timing
- `en` rising at edge E: the FSM is in RECEIVE after E. The earliest accepted `sample` is in the cycle following E.
- The final `sample` in cycle N: `data_o` and `valid_o` are valid in cycle N+1, i.e. one-clock latency.
- `valid_o` drops the cycle after the accepting edge unless a new word completes on that same edge.
- `ovr_clr_i` and an overrun on the same edge: set wins, `ovr_o`=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SPI_RX_OVR_EN`.
- Defined:
  - On overrun, the new word is dropped and `data_o` keeps the older unread word.
  - `ovr_o` sets and holds until `ovr_clr_i`=1 (or reset).
  - Ports `ovr_o` and `ovr_clr_i` are present.
- Undefined:
  - On overrun, the new word overwrites `data_o` and `valid_o` stays 1.
  - No overrun flag; ports `ovr_o` and `ovr_clr_i` are absent.

## Test plan
- **MSB-first:** `lsbf`=0, `en`=1, 8 strobes with `sdi`=1,0,1,0,0,1,0,1 -> `data_o`=0xA5 and `valid_o`=1 exactly one cycle after the 8th strobe; `busy_o`=0 afterwards.
- **LSB-first:** `lsbf`=1, `sdi`=1,0,0,0,0,0,0,0 -> `data_o`=0x01; changing `lsbf` mid-frame has no effect.
- **Back-to-back:** words 0x3C then 0xC3 with `ready_i`=1 held -> two single-cycle `valid_o` pulses carrying 0x3C and 0xC3; no overrun.
- **Abort and reset:**
  - Drop `en` after 5 bits -> no `valid_o`.
  - A new frame sending 0xFF -> 0xFF.
  - Reset after 3 bits -> all outputs 0, and the next frame 0x5A is received correctly.
- **Overrun:** 0x11 left unread (`ready_i`=0), then 0x22 completes.
  - With macro: `data_o`=0x11, `ovr_o`=1; `ovr_clr_i` pulse -> `ovr_o`=0.
  - Without macro: `data_o`=0x22, `valid_o`=1.
- **Accept coincident with completion:** `ready_i`=1 on the edge 0x77 completes over unread 0x66 -> `valid_o` stays 1, `data_o`=0x77, `ovr_o`=0.

Source files
------------

// File: rtl/spi_receiver.sv
// spi_receiver: SPI serial-to-parallel receiver with a one-entry valid/ready holding register.
// Define SPI_RX_OVR_EN to keep the unread word on overrun and expose a sticky ovr_o flag.
module spi_receiver #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en,
    input  logic              sample,
    input  logic              sdi,
    input  logic              lsbf,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o
`ifdef SPI_RX_OVR_EN
    ,
    output logic              ovr_o,
    input  logic              ovr_clr_i
`endif
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic {IDLE, RECEIVE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n, shifted;
    logic lsbf_q, lsbf_n, done, load;
    always_comb begin
        shifted = lsbf_q ? {sdi, shreg[DATA_W-1:1]} : {shreg[DATA_W-2:0], sdi};
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        lsbf_n  = lsbf_q;
        done    = 1'b0;
        if (state == IDLE) begin
            if (en) begin
                state_n = RECEIVE;
                cnt_n   = '0;
                lsbf_n  = lsbf;
            end
        end else if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (sample) begin
            shreg_n = shifted;
            done    = cnt == CW'(DATA_W - 1);
            cnt_n   = done ? '0 : cnt + 1'b1;
        end
    end
`ifdef SPI_RX_OVR_EN
    logic overrun;
    assign overrun = done & valid_o & ~ready_i;
    assign load    = done & ~overrun;
    always_ff @(posedge clk_i) begin
        if (rst_i) ovr_o <= 1'b0;
        else       ovr_o <= overrun | (ovr_o & ~ovr_clr_i);
    end
`else
    assign load = done;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            lsbf_q  <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            lsbf_q  <= lsbf_n;
            if (load) data_o <= shreg_n;
            valid_o <= load | (valid_o & ~ready_i);
        end
    end
    assign busy_o = (state == RECEIVE) && (cnt != '0);
endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: directed tests of spi_receiver, one task per scenario.
module tb_spi_receiver;
    logic clk = 0, rst = 1, en = 0, sample = 0, sdi = 0, lsbf = 0, ready = 0;
    logic [7:0] data_o;
    logic valid_o, busy_o;
    int vec = 0, errs = 0;
`ifdef SPI_RX_OVR_EN
    logic ovr_o, ovr_clr = 0;
`endif

    spi_receiver #(.DATA_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .en(en), .sample(sample), .sdi(sdi), .lsbf(lsbf),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready), .busy_o(busy_o)
`ifdef SPI_RX_OVR_EN
        , .ovr_o(ovr_o), .ovr_clr_i(ovr_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic l);
        en = 1; lsbf = l;
        tick();
    endtask

    task automatic end_frame();
        en = 0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        sample = 1; sdi = b;
        tick();
        sample = 0;
    endtask

    task automatic send_word(input logic [7:0] w, input int n, input logic l);
        for (int i = 0; i < n; i++) send_bit(l ? w[i] : w[7-i]);
    endtask

    task automatic drain();
        ready = 1;
        tick();
        ready = 0;
    endtask

    task automatic check_ovr(input string name, input logic exp);
`ifdef SPI_RX_OVR_EN
        vec++;
        if (ovr_o !== exp) begin errs++; $display("FAIL %s ovr got %b exp %b", name, ovr_o, exp); end
`endif
    endtask

    task automatic test_reset();
        vec++; if (data_o !== 8'h00) begin errs++; $display("FAIL reset data got %h exp 00", data_o); end
        vec++; if (valid_o !== 1'b0) begin errs++; $display("FAIL reset valid got %b exp 0", valid_o); end
        vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset busy got %b exp 0", busy_o); end
        check_ovr("reset", 1'b0);
    endtask

    task automatic test_msb_first();
        start_frame(0);
        vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL msb busy_start got %b exp 0", busy_o); end
        send_word(8'hA5, 7, 0);
        vec++; if (busy_o !== 1'b1) begin errs++; $display("FAIL msb busy_mid got %b exp 1", busy_o); end
        vec++; if (valid_o !== 1'b0) begin errs++; $display("FAIL msb valid_early got %b exp 0", valid_o); end
        send_bit(1);
        vec++; if (data_o !== 8'hA5) begin errs++; $display("FAIL msb data got %h exp a5", data_o); end
        vec++; if (valid_o !== 1'b1) begin errs++; $display("FAIL msb valid got %b exp 1", valid_o); end
        vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL msb busy_end got %b exp 0", busy_o); end
        tick();
        vec++; if (valid_o !== 1'b1 || data_o !== 8'hA5) begin errs++; $display("FAIL msb hold got %b/%h exp 1/a5", valid_o, data_o); end
        drain();
        vec++; if (valid_o !== 1'b0) begin errs++; $display("FAIL msb drained got %b exp 0", valid_o); end
        end_frame();
    endtask

    task automatic test_lsb_first();
        start_frame(1);
        send_bit(1);
        lsbf = 0;
        send_word(8'h00, 7, 1);
        vec++; if (data_o !== 8'h01) begin errs++; $display("FAIL lsb data got %h exp 01", data_o); end
        vec++; if (valid_o !== 1'b1) begin errs++; $display("FAIL lsb valid got %b exp 1", valid_o); end
        drain();
        end_frame();
    endtask

    task automatic test_back_to_back();
        ready = 1;
        start_frame(0);
        send_word(8'h3C, 8, 0);
        vec++; if (valid_o !== 1'b1 || data_o !== 8'h3C) begin errs++; $display("FAIL b2b first got %b/%h exp 1/3c", valid_o, data_o); end
        send_bit(1);
        vec++; if (valid_o !== 1'b0) begin errs++; $display("FAIL b2b pulse1 got %b exp 0", valid_o); end
        send_word(8'h87, 7, 0);
        vec++; if (valid_o !== 1'b1 || data_o !== 8'hC3) begin errs++; $display("FAIL b2b second got %b/%h exp 1/c3", valid_o, data_o); end
        tick();
        vec++; if (valid_o !== 1'b0) begin errs++; $display("FAIL b2b pulse2 got %b exp 0", valid_o); end
        check_ovr("b2b", 1'b0);
        ready = 0;
        end_frame();
    endtask

    task automatic test_abort_reset();
        start_frame(0);
        send_word(8'hFF, 5, 0);
        en = 0;
        tick();
        vec++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL abort got %b/%b exp 0/0", valid_o, busy_o); end
        sample = 1; sdi = 1;
        tick(); tick();
        sample = 0;
        start_frame(0);
        send_word(8'hFF, 8, 0);
        vec++; if (valid_o !== 1'b1 || data_o !== 8'hFF) begin errs++; $display("FAIL abort_new got %b/%h exp 1/ff", valid_o, data_o); end
        tick();
        start_frame(0);
        send_word(8'hFF, 3, 0);
        rst = 1; en = 0;
        tick();
        rst = 0;
        vec++; if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL rst_mid got %h/%b/%b exp 00/0/0", data_o, valid_o, busy_o); end
        check_ovr("rst_mid", 1'b0);
        start_frame(0);
        send_word(8'h5A, 8, 0);
        vec++; if (valid_o !== 1'b1 || data_o !== 8'h5A) begin errs++; $display("FAIL rst_next got %b/%h exp 1/5a", valid_o, data_o); end
        drain();
        end_frame();
    endtask

    task automatic test_overrun();
        start_frame(0);
        send_word(8'h11, 8, 0);
        vec++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin errs++; $display("FAIL ovr first got %b/%h exp 1/11", valid_o, data_o); end
        send_word(8'h22, 8, 0);
        vec++; if (valid_o !== 1'b1) begin errs++; $display("FAIL ovr valid got %b exp 1", valid_o); end
`ifdef SPI_RX_OVR_EN
        vec++; if (data_o !== 8'h11) begin errs++; $display("FAIL ovr data got %h exp 11", data_o); end
        check_ovr("ovr_set", 1'b1);
        tick();
        check_ovr("ovr_sticky", 1'b1);
        ovr_clr = 1;
        tick();
        ovr_clr = 0;
        check_ovr("ovr_clr", 1'b0);
`else
        vec++; if (data_o !== 8'h22) begin errs++; $display("FAIL ovr data got %h exp 22", data_o); end
`endif
        drain();
        end_frame();
    endtask

    task automatic test_coincident();
        start_frame(0);
        send_word(8'h66, 8, 0);
        send_word(8'h77, 7, 0);
        ready = 1;
        send_bit(1);
        ready = 0;
        vec++; if (valid_o !== 1'b1 || data_o !== 8'h77) begin errs++; $display("FAIL coinc got %b/%h exp 1/77", valid_o, data_o); end
        check_ovr("coinc", 1'b0);
        tick();
        vec++; if (valid_o !== 1'b1) begin errs++; $display("FAIL coinc hold got %b exp 1", valid_o); end
        drain();
        vec++; if (valid_o !== 1'b0) begin errs++; $display("FAIL coinc drained got %b exp 0", valid_o); end
        end_frame();
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_abort_reset();
        test_overrun();
        test_coincident();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
